// File: rtl/axistream_pkg.sv
// Shared types, default widths and helpers for the AXI-Stream width converters.
package axistream_pkg;

  localparam int DEF_TDATA_IN_WIDTH  = 64;
  localparam int DEF_TDATA_OUT_WIDTH = 16;
  localparam int DEF_TID_WIDTH       = 4;
  localparam int DEF_TDEST_WIDTH     = 4;
  localparam int KEEP_MAX            = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  // A slice is null when none of its byte lanes is kept.
  function automatic logic slice_is_null(input logic [KEEP_MAX-1:0] keep);
    return ~|keep;
  endfunction

endpackage

// File: rtl/axistream_slice_sel.sv
// Combinational slice selector: finds the first, final and next non-null
// slice of a wide beat from its tkeep bits. An all-null beat maps to slice 0.
module axistream_slice_sel
  import axistream_pkg::*;
#(
  parameter int RATIO       = 4,
  parameter int SLICE_BYTES = 2,
  parameter int IDX_W       = 2
) (
  input  logic [RATIO*SLICE_BYTES-1:0] keep,
  input  logic [IDX_W-1:0]             idx,
  output logic [IDX_W-1:0]             first_idx,
  output logic [IDX_W-1:0]             final_idx,
  output logic [IDX_W-1:0]             next_idx
);

  logic [RATIO-1:0] live;

  always_comb begin
    live      = '0;
    first_idx = '0;
    final_idx = '0;
    next_idx  = idx;
    for (int i = 0; i < RATIO; i++)
      live[i] = ~slice_is_null(KEEP_MAX'(keep[i*SLICE_BYTES +: SLICE_BYTES]));
    for (int i = RATIO - 1; i >= 0; i--)
      if (live[i]) first_idx = IDX_W'(i);
    for (int i = 0; i < RATIO; i++)
      if (live[i]) final_idx = IDX_W'(i);
    for (int i = RATIO - 1; i >= 0; i--)
      if (live[i] && (IDX_W'(i) > idx)) next_idx = IDX_W'(i);
  end

endmodule

// File: rtl/axistream_downsizer.sv
// AXI-Stream downsizer: splits each wide beat into narrow slices, LSB slice first.
// Define AXISTREAM_DOWNSIZER_NULL_SKIP_EN to suppress slices with no kept bytes.
module axistream_downsizer
  import axistream_pkg::*;
#(
  parameter int TDATA_IN_WIDTH  = DEF_TDATA_IN_WIDTH,
  parameter int TDATA_OUT_WIDTH = DEF_TDATA_OUT_WIDTH,
  parameter int TID_WIDTH       = DEF_TID_WIDTH,
  parameter int TDEST_WIDTH     = DEF_TDEST_WIDTH
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [TDATA_IN_WIDTH-1:0]    s_tdata,
  input  logic [TDATA_IN_WIDTH/8-1:0]  s_tstrb,
  input  logic [TDATA_IN_WIDTH/8-1:0]  s_tkeep,
  input  logic                         s_tlast,
  input  logic [TID_WIDTH-1:0]         s_tid,
  input  logic [TDEST_WIDTH-1:0]       s_tdest,
  input  logic                         s_twakeup,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [TDATA_OUT_WIDTH-1:0]   m_tdata,
  output logic [TDATA_OUT_WIDTH/8-1:0] m_tstrb,
  output logic [TDATA_OUT_WIDTH/8-1:0] m_tkeep,
  output logic                         m_tlast,
  output logic [TID_WIDTH-1:0]         m_tid,
  output logic [TDEST_WIDTH-1:0]       m_tdest,
  output logic                         m_twakeup
);

  localparam int RATIO = TDATA_IN_WIDTH / TDATA_OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IB    = TDATA_IN_WIDTH / 8;
  localparam int OB    = TDATA_OUT_WIDTH / 8;

  if ((TDATA_IN_WIDTH % 8 != 0) || (TDATA_OUT_WIDTH % 8 != 0)) begin : g_err_bytes
    $error("axistream_downsizer: tdata widths must be multiples of 8");
  end
  if (TDATA_IN_WIDTH % TDATA_OUT_WIDTH != 0) begin : g_err_div
    $error("axistream_downsizer: TDATA_OUT_WIDTH must divide TDATA_IN_WIDTH");
  end
  if (RATIO < 2) begin : g_err_ratio
    $error("axistream_downsizer: width ratio must be at least 2");
  end

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [TDATA_IN_WIDTH-1:0]  buf_data;
  logic [IB-1:0]              buf_strb;
  logic [IB-1:0]              buf_keep;
  logic                       buf_last;
  logic [TID_WIDTH-1:0]       buf_id;
  logic [TDEST_WIDTH-1:0]     buf_dest;
  logic                       twakeup_r;

  logic [IDX_W-1:0] first_in;
  logic [IDX_W-1:0] final_idx;
  logic [IDX_W-1:0] next_idx;
  logic             last_slice;
  logic             accept;

`ifdef AXISTREAM_DOWNSIZER_NULL_SKIP_EN
  logic [IDX_W-1:0] in_final;
  logic [IDX_W-1:0] in_next;
  logic [IDX_W-1:0] buf_first;

  // The incoming beat needs its first live slice at load time, while the
  // buffered beat drives stepping and end-of-beat detection.
  axistream_slice_sel #(.RATIO(RATIO), .SLICE_BYTES(OB), .IDX_W(IDX_W)) u_sel_in (
    .keep      (s_tkeep),
    .idx       ('0),
    .first_idx (first_in),
    .final_idx (in_final),
    .next_idx  (in_next)
  );

  axistream_slice_sel #(.RATIO(RATIO), .SLICE_BYTES(OB), .IDX_W(IDX_W)) u_sel_buf (
    .keep      (buf_keep),
    .idx       (idx),
    .first_idx (buf_first),
    .final_idx (final_idx),
    .next_idx  (next_idx)
  );
`else
  assign first_in  = '0;
  assign final_idx = IDX_W'(RATIO - 1);
  assign next_idx  = idx + IDX_W'(1);
`endif

  assign last_slice = (idx == final_idx);
  // Combinational m_tready -> s_tready path keeps consecutive beats bubble-free.
  assign s_tready   = (state == ST_EMPTY) || (last_slice && m_tready);
  assign accept     = s_tvalid && s_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_EMPTY;
      idx       <= '0;
      buf_data  <= '0;
      buf_strb  <= '0;
      buf_keep  <= '0;
      buf_last  <= 1'b0;
      buf_id    <= '0;
      buf_dest  <= '0;
      twakeup_r <= 1'b0;
    end else begin
      twakeup_r <= s_twakeup || (state == ST_SEND);
      if (accept) begin
        state    <= ST_SEND;
        idx      <= first_in;
        buf_data <= s_tdata;
        buf_strb <= s_tstrb;
        buf_keep <= s_tkeep;
        buf_last <= s_tlast;
        buf_id   <= s_tid;
        buf_dest <= s_tdest;
      end else if (state == ST_SEND && m_tready) begin
        if (last_slice) begin
          state <= ST_EMPTY;
          idx   <= '0;
        end else begin
          idx <= next_idx;
        end
      end
    end
  end

  assign m_tvalid  = (state == ST_SEND);
  assign m_tdata   = buf_data[int'(idx)*TDATA_OUT_WIDTH +: TDATA_OUT_WIDTH];
  assign m_tstrb   = buf_strb[int'(idx)*OB +: OB];
  assign m_tkeep   = buf_keep[int'(idx)*OB +: OB];
  assign m_tlast   = buf_last && last_slice;
  assign m_tid     = buf_id;
  assign m_tdest   = buf_dest;
  assign m_twakeup = twakeup_r;

endmodule
